// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter.
// Holds the FSM state encoding, the read/write and requester ID encodings,
// the default bus widths, and a helper that returns the opposite requester.
package core_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic other_req(input logic id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_rr_arb2.sv
// Two-input round-robin grant logic.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_req, d_req - request lines from the I-side and D-side
//   update_en    - commit the current grant into last_grant
//   grant_valid  - at least one request is present
//   grant_id     - REQ_I or REQ_D; on a tie, the side that did not win last
// last_grant resets to REQ_I so the D-side wins the first tie.
module rr_arb2
    import core_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic update_en,
    output logic grant_valid,
    output logic grant_id
);

    logic last_grant;

    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = REQ_I;
        if (i_req && d_req) begin
            grant_id = other_req(last_grant);
        end else if (d_req) begin
            grant_id = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_I;
        end else if (update_en && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Arbiter between the core's instruction-fetch (I) and data (D) request
// paths in front of the single-pulse AXI master request interface.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   i_valid_i, i_addr_i            - I-side line read request
//   i_done_o, i_rdata_o            - I-side completion pulse and read line
//   d_valid_i, d_rw_i, d_addr_i,
//   d_wdata_i                      - D-side read/write request
//   d_done_o, d_rdata_o            - D-side completion pulse and read line
//   bus_req_o                      - one-cycle request pulse to the master
//   bus_rw_o, bus_addr_o,
//   bus_wdata_o                    - transaction fields, held until the next grant
//   bus_rdata_i, bus_rd_over_i,
//   bus_wr_over_i                  - master read data and completion pulses
//   stall_o                        - requests pending or transaction in flight
//   err_o                          - sticky watchdog timeout flag
//   dbg_state                      - current FSM state encoding
// Handshake: a requester raises valid and holds it until its done pulse;
// the request is sampled only in IDLE and, once granted, always completes.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int LINE_W         = LINE_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_done_o,
    output logic [LINE_W-1:0] i_rdata_o,
    input  logic              d_valid_i,
    input  logic              d_rw_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic              d_done_o,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              bus_req_o,
    output logic              bus_rw_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [LINE_W-1:0] bus_wdata_o,
    input  logic [LINE_W-1:0] bus_rdata_i,
    input  logic              bus_rd_over_i,
    input  logic              bus_wr_over_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic             grant_valid, grant_id, grant_take;
    logic             gnt_id;
    logic             over_match;
    logic             timeout_flag;
    logic [CNT_W-1:0] wd_cnt;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_valid_i),
        .d_req       (d_valid_i),
        .update_en   (grant_take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Only the completion pulse matching the held transaction type counts.
    assign over_match = (bus_rw_o == RW_READ) ? bus_rd_over_i : bus_wr_over_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (over_match || wd_cnt == WD_LAST) begin
                    state_next = ST_RESP;
                end
            end
            // After a timeout the master still owes a pulse; absorb it in DRAIN.
            ST_RESP:  state_next = timeout_flag ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (over_match) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id       <= REQ_I;
            bus_rw_o     <= RW_WRITE;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
            err_o        <= 1'b0;
            i_rdata_o    <= '0;
            d_rdata_o    <= '0;
        end else begin
            if (grant_take) begin
                gnt_id <= grant_id;
                if (grant_id == REQ_I) begin
                    bus_rw_o    <= RW_READ;
                    bus_addr_o  <= i_addr_i;
                    bus_wdata_o <= '0;
                end else begin
                    bus_rw_o    <= d_rw_i;
                    bus_addr_o  <= d_addr_i;
                    bus_wdata_o <= d_wdata_i;
                end
            end
            case (state)
                ST_ISSUE: begin
                    wd_cnt       <= '0;
                    timeout_flag <= 1'b0;
                end
                ST_WAIT: begin
                    if (over_match) begin
                        if (bus_rw_o == RW_READ) begin
                            if (gnt_id == REQ_I) i_rdata_o <= bus_rdata_i;
                            else                 d_rdata_o <= bus_rdata_i;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        err_o        <= 1'b1;
                        timeout_flag <= 1'b1;
                        if (gnt_id == REQ_I) i_rdata_o <= '0;
                        else                 d_rdata_o <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o = (state == ST_ISSUE);
    assign i_done_o  = (state == ST_RESP) && (gnt_id == REQ_I);
    assign d_done_o  = (state == ST_RESP) && (gnt_id == REQ_D);
    assign stall_o   = i_valid_i | d_valid_i | (state != ST_IDLE);
    assign dbg_state = state;

endmodule
